// File: rtl/id_ex_shift_stage_if.sv
// ID/EX shift-stage bundle: decode fields and hazard inputs in, EX-slot fields out.
// Latency: none, wires only.
// Backpressure: stall/flush from the hazard unit travel inside this bundle.
interface id_ex_shift_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    // decode slot
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [3:0]        id_imm4;
    logic              id_reg_write;

    // forwarding sources
    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    // hazard control
    logic              stall;
    logic              flush;

    // EX slot
    logic              ex_valid;
    logic              ex_is_shift;
    logic [1:0]        ex_shift_op;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic [CNT_W-1:0]  shift_count;

    // Decode/hazard side drives the slot, consumes the EX fields.
    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm4, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_data,
               stall, flush,
        input  ex_valid, ex_is_shift, ex_shift_op, ex_a, ex_b,
               ex_rd, ex_reg_write, shift_count
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm4, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               wb_reg_write, wb_rd, wb_data,
               stall, flush,
        output ex_valid, ex_is_shift, ex_shift_op, ex_a, ex_b,
               ex_rd, ex_reg_write, shift_count
    );
endinterface

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register for the shifter: forwards rs/rt, decodes shift op, counts shifts.
// Latency: one cycle from decode slot to EX outputs.
// Backpressure: stall holds every output; flush squashes the entering instruction (wins over stall).
module id_ex_shift_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    id_ex_shift_stage_if.slave      bus
);

    localparam logic [3:0] OPC_SLL  = 4'b0100;
    localparam logic [3:0] OPC_SRA  = 4'b0101;
    localparam logic [3:0] OPC_ROR  = 4'b0110;

    localparam logic [1:0] SOP_SLL  = 2'b00;
    localparam logic [1:0] SOP_SRA  = 2'b01;
    localparam logic [1:0] SOP_ROR  = 2'b10;
    localparam logic [1:0] SOP_NONE = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Forwarding picks the youngest in-flight writer; r0 is hardwired to zero
    // even if some stage claims to write it.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              exm_we,
        input logic [REG_AW-1:0] exm_dst,
        input logic [DATA_W-1:0] exm_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] v;
        if (src == '0)
            v = '0;
        else if (exm_we && (exm_dst == src))
            v = exm_val;
        else if (wb_we && (wb_dst == src))
            v = wb_val;
        else
            v = rf_data;
        return v;
    endfunction

    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic              w_is_shift;
    logic [1:0]        w_shift_op;
    logic [DATA_W-1:0] w_b;
    logic              w_reg_write;
    logic              w_load;

    logic              r_ex_valid;
    logic              r_ex_is_shift;
    logic [1:0]        r_ex_shift_op;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_reg_write;
    logic [CNT_W-1:0]  r_shift_count;

    // Resolve both source operands against the EX/MEM and MEM/WB writers.
    always_comb begin
        w_rs_fwd = fwd_sel(bus.id_rs, bus.id_rs_data,
                           bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                           bus.wb_reg_write, bus.wb_rd, bus.wb_data);
        w_rt_fwd = fwd_sel(bus.id_rt, bus.id_rt_data,
                           bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                           bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    end

    // Decode the shift kind; a bubble in decode never counts as a shift.
    always_comb begin
        w_is_shift = 1'b0;
        w_shift_op = SOP_NONE;
        if (bus.id_valid) begin
            case (bus.id_opcode)
                OPC_SLL: begin w_is_shift = 1'b1; w_shift_op = SOP_SLL; end
                OPC_SRA: begin w_is_shift = 1'b1; w_shift_op = SOP_SRA; end
                OPC_ROR: begin w_is_shift = 1'b1; w_shift_op = SOP_ROR; end
                default: begin w_is_shift = 1'b0; w_shift_op = SOP_NONE; end
            endcase
        end
    end

    // Shifts take the zero-extended immediate as amount; everything else passes rt.
    always_comb begin
        w_b = w_rt_fwd;
        if (w_is_shift)
            w_b = {{(DATA_W-4){1'b0}}, bus.id_imm4};
    end

    assign w_reg_write = bus.id_reg_write & bus.id_valid;
    assign w_load      = ~bus.flush & ~bus.stall;

    // EX slot register: flush clears, stall holds, otherwise capture decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_is_shift  <= 1'b0;
            r_ex_shift_op  <= SOP_NONE;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid     <= 1'b0;
            r_ex_is_shift  <= 1'b0;
            r_ex_shift_op  <= SOP_NONE;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
        end else if (w_load) begin
            r_ex_valid     <= bus.id_valid;
            r_ex_is_shift  <= w_is_shift;
            r_ex_shift_op  <= w_shift_op;
            r_ex_a         <= w_rs_fwd;
            r_ex_b         <= w_b;
            r_ex_rd        <= bus.id_rd;
            r_ex_reg_write <= w_reg_write;
        end
    end

    // Count shifts actually entering EX; wraps silently at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_shift_count <= '0;
        else if (w_load && w_is_shift)
            r_shift_count <= r_shift_count + CNT_ONE;
    end

    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_is_shift  = r_ex_is_shift;
    assign bus.ex_shift_op  = r_ex_shift_op;
    assign bus.ex_a         = r_ex_a;
    assign bus.ex_b         = r_ex_b;
    assign bus.ex_rd        = r_ex_rd;
    assign bus.ex_reg_write = r_ex_reg_write;
    assign bus.shift_count  = r_shift_count;

endmodule
